pee_host_bridge: RTL

//  Downstream of the Python Execution Engine: takes its python_req/python_code_addr

---
 rtl/pee_host_bridge.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pee_host_bridge.sv
// Bridges Python Execution Engine requests to the host runtime over a tagged
// valid/ready link, one request outstanding, returning results as a 1-cycle ack.
module pee_host_bridge #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       python_req,
   input  logic [31:0]                python_code_addr,
   output logic                       python_ack,
   output logic [31:0]                python_result,
   output logic                       python_error,
   output logic                       host_req_valid,
   input  logic                       host_req_ready,
   output logic [31:0]                host_req_addr,
   output logic [TAG_W-1:0]           host_req_tag,
   input  logic                       host_rsp_valid,
   input  logic [TAG_W-1:0]           host_rsp_tag,
   input  logic [31:0]                host_rsp_data,
   input  logic                       host_rsp_error,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic [15:0]                drop_count,
   output logic [15:0]                stale_count,
   output logic                       busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_RESPOND  = 2'd3
   } state_t;

   state_t           state;
   logic             prev_req;
   logic [31:0]      mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic [TAG_W-1:0] out_tag;

   logic edge_c;
   logic full_c;
   logic empty_c;
   logic pop_c;
   logic push_c;
   logic drop_c;
   logic accept_c;
   logic match_c;
   logic stale_c;

   assign edge_c   = python_req & ~prev_req;
   assign full_c   = (count == LW'(DEPTH));
   assign empty_c  = (count == '0);
   assign pop_c    = (state == ST_IDLE) & ~empty_c & ~flush;
   // A full FIFO still accepts when the head leaves on the same edge
   assign push_c   = edge_c & ~flush & (~full_c | pop_c);
   assign drop_c   = edge_c & ~flush & full_c & ~pop_c;
   assign accept_c = (state == ST_ISSUE) & host_req_ready;
   assign match_c  = (state == ST_WAIT_RSP) & host_rsp_valid & ~flush &
                     (host_rsp_tag == out_tag);
   assign stale_c  = host_rsp_valid & ~match_c;

   assign fifo_level = count;
   assign busy       = (state != ST_IDLE) | ~empty_c;

   // Rising-edge detector on the request line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_req <= 1'b0;
      else        prev_req <= python_req;
   end

   // Request FIFO storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= python_code_addr;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_c, pop_c})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   // Saturating drop / stale counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_count  <= '0;
         stale_count <= '0;
      end else begin
         if (drop_c && drop_count != 16'hFFFF)   drop_count  <= drop_count + 16'd1;
         if (stale_c && stale_count != 16'hFFFF) stale_count <= stale_count + 16'd1;
      end
   end

   // Request FSM; the tag advances on any host accept, even one cut short by flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         host_req_valid <= 1'b0;
         host_req_addr  <= '0;
         host_req_tag   <= '0;
         out_tag        <= '0;
         python_ack     <= 1'b0;
         python_result  <= '0;
         python_error   <= 1'b0;
      end else begin
         python_ack <= 1'b0;
         if (accept_c) host_req_tag <= host_req_tag + TAG_W'(1);
         if (flush) begin
            state          <= ST_IDLE;
            host_req_valid <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (pop_c) begin
                     state          <= ST_ISSUE;
                     host_req_valid <= 1'b1;
                     host_req_addr  <= mem[rd_ptr];
                  end
               end
               ST_ISSUE: begin
                  if (host_req_ready) begin
                     state          <= ST_WAIT_RSP;
                     host_req_valid <= 1'b0;
                     out_tag        <= host_req_tag;
                  end
               end
               ST_WAIT_RSP: begin
                  if (match_c) begin
                     state         <= ST_RESPOND;
                     python_ack    <= 1'b1;
                     python_result <= host_rsp_data;
                     python_error  <= host_rsp_error;
                  end
               end
               ST_RESPOND: state <= ST_IDLE;
               default:    state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
